// File: rtl/uart_pkg.sv
// Shared definitions for the console UART transmit path: FSM state encoding,
// frame constants and the console MMIO address used by the core-side decode.
package uart_pkg;

   // Transmitter FSM states; one frame walks IDLE -> START -> DATA -> STOP.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   localparam int   UART_DATA_BITS  = 8;
   localparam logic UART_IDLE_LEVEL = 1'b1;

   // Address the per-core store decode matches to raise req_valid.
   localparam logic [31:0] UART_TX_ADDR = 32'h4000_0000;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational masked round-robin arbiter. Requests at or above the pointer
// win first (lowest index among them); if none, the lowest request overall
// wins. The grant is one-hot, or zero when nothing is requested.
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int PTR_W   = 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant
);

   logic [NUM_REQ-1:0] mask;
   logic [NUM_REQ-1:0] masked;
   logic               found;

   // Priority-encode the masked requests first, then fall back to the raw ones.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path leaves
      // it unassigned and no latch is inferred.
      mask   = '0;
      grant  = '0;
      found  = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         mask[i] = (i >= int'(ptr));
      end
      masked = req & mask;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (masked[i] && !found) begin
            grant[i] = 1'b1;
            found    = 1'b1;
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (req[i] && !found) begin
            grant[i] = 1'b1;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Console UART transmitter shared by NUM_REQ cores. Accepts one byte at a time
// via round-robin arbitration (with an optional per-requester lock so
// multi-byte messages stay contiguous) and sends it as an 8N1 frame.
// Optional feature macro: UART_TX_ARB_SIM_PRINT_EN -- when defined, every
// accepted byte is echoed to the simulation console with $write("%c").
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int  NUM_REQ      = 2,
   parameter int  CLKS_PER_BIT = 16,
   localparam int GID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [8*NUM_REQ-1:0]   req_data,
   input  logic [NUM_REQ-1:0]     req_lock,
   output logic [NUM_REQ-1:0]     req_ready,
   output logic                   uart_tx,
   output logic                   busy,
   output logic [GID_W-1:0]       grant_id
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_TC   = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0]       LAST_BIT = 3'(UART_DATA_BITS - 1);

   state_t                    state_q, state_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [2:0]                bit_q, bit_d;
   logic [UART_DATA_BITS-1:0] shift_q, shift_d;
   logic                      tx_q, tx_d;
   logic [GID_W-1:0]          rr_q, rr_d;
   logic [GID_W-1:0]          gid_q, gid_d;
   logic                      own_v_q, own_v_d;
   logic [GID_W-1:0]          own_id_q, own_id_d;

   logic [NUM_REQ-1:0]        rr_grant;
   logic [NUM_REQ-1:0]        own_mask;
   logic [NUM_REQ-1:0]        ready_int;
   logic                      lock_hold;
   logic                      accept;
   logic [GID_W-1:0]          sel_idx;
   logic [7:0]                sel_byte;
   logic                      cnt_tc;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (GID_W)
   ) u_rr (
      .req   (req_valid),
      .ptr   (rr_q),
      .grant (rr_grant)
   );

   // Arbitration: a holding lock owner shuts everyone else out, else round-robin.
   always_comb begin
      own_mask  = '0;
      ready_int = '0;
      sel_idx   = '0;
      sel_byte  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         own_mask[i] = (GID_W'(i) == own_id_q);
      end
      lock_hold = own_v_q && req_lock[own_id_q];
      if (state_q == IDLE && rst_n) begin
         ready_int = lock_hold ? (own_mask & req_valid) : rr_grant;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (ready_int[i]) begin
            sel_idx  = GID_W'(i);
            sel_byte = req_data[8*i +: 8];
         end
      end
      accept = |(req_valid & ready_int);
   end

   assign req_ready = ready_int;
   assign uart_tx   = tx_q;
   assign busy      = (state_q != IDLE);
   assign grant_id  = gid_q;
   assign cnt_tc    = (cnt_q == CNT_TC);

   // Next-state logic: handshake in IDLE, then timed START / DATA / STOP bits.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      tx_d     = tx_q;
      rr_d     = rr_q;
      gid_d    = gid_q;
      own_v_d  = own_v_q;
      own_id_d = own_id_q;
      case (state_q)
         IDLE: begin
            tx_d = UART_IDLE_LEVEL;
            if (!lock_hold) begin
               own_v_d = 1'b0;
            end
            if (accept) begin
               shift_d  = sel_byte;
               gid_d    = sel_idx;
               rr_d     = (sel_idx == GID_W'(NUM_REQ - 1)) ? '0 : GID_W'(sel_idx + 1'b1);
               own_v_d  = req_lock[sel_idx];
               own_id_d = sel_idx;
               cnt_d    = '0;
               bit_d    = '0;
               tx_d     = 1'b0;
               state_d  = START;
            end
         end
         START: begin
            if (cnt_tc) begin
               cnt_d   = '0;
               tx_d    = shift_q[0];
               state_d = DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DATA: begin
            if (cnt_tc) begin
               cnt_d = '0;
               if (bit_q == LAST_BIT) begin
                  tx_d    = UART_IDLE_LEVEL;
                  state_d = STOP;
               end else begin
                  bit_d   = bit_q + 1'b1;
                  shift_d = shift_q >> 1;
                  tx_d    = shift_q[1];
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         STOP: begin
            if (cnt_tc) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register with synchronous active-low reset; a reset aborts any frame.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples the values from before this edge.
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         bit_q    <= '0;
         // NOTE: the shift register is reset too; it is small and keeping it
         // defined avoids X on the line if a frame were ever entered early.
         shift_q  <= '0;
         tx_q     <= UART_IDLE_LEVEL;
         rr_q     <= '0;
         gid_q    <= '0;
         own_v_q  <= 1'b0;
         own_id_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         tx_q     <= tx_d;
         rr_q     <= rr_d;
         gid_q    <= gid_d;
         own_v_q  <= own_v_d;
         own_id_q <= own_id_d;
      end
   end

`ifdef UART_TX_ARB_SIM_PRINT_EN
   // Simulation-only console echo of each accepted byte.
   always @(posedge clk) begin
      if (accept) begin
         $write("%c", sel_byte);
      end
   end
`else
   // No console echo in this build.
`endif

endmodule
